pmem_line_responder: RTL
========================

# pmem_line_responder

Physical-memory responder for the cache's 256-bit line interface: the far end of the pmem_read / pmem_write / pmem_resp handshake driven by the cache. It holds a line-granular backing store and answers each request after a programmable latency. It has one registered pmem_resp pulse per request. It replaces the behavioural memory model in synthesizable system builds and serves as the reference responder for cache verification.

## Interface
- LINES, default 64, number of 256-bit lines in the backing store (power of two, ≥2)
- LATENCY, default 10, wait cycles between request acceptance and response (≥1)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- pmem_read  in  1  line read request, held until pmem_resp
- pmem_write  in  1  line write request, held until pmem_resp
- pmem_address  in  32  byte address; bits [4:0] ignored, line index = address[5+log2(LINES)-1:5]
- pmem_wdata  in  256  write line, stable while pmem_write is high
- pmem_rdata  out  256  read line, registered
- pmem_resp  out  1  one-cycle completion pulse, registered
- pmem_err  out  1  sticky protocol/range error flag

## Operation
- FSM states: IDLE, WAIT, RESP, RECOVER.
- IDLE: if pmem_read or pmem_write is high, latch op (write if pmem_write), line index, and range flag. Load cnt = LATENCY-1. Go to WAIT.
- WAIT: if the latched op's request line drops, abort. No array update, no resp, go to IDLE. Otherwise, if cnt == 0, go to RESP, else cnt--.
- On the edge entering RESP:
  - A write stores pmem_wdata (sampled at that edge) into the array.
  - A read loads pmem_rdata from the array.
- RESP: pmem_resp = 1 for exactly this cycle. Go to RECOVER unconditionally.
- RECOVER: requests ignored for one cycle, which absorbs the initiator's deassertion. Go to IDLE.
- Out of range (address[31:5] ≥ LINES):
  - The request completes with normal timing.
  - A write is dropped.
  - A read returns all-zero rdata.
  - pmem_err is set.
- pmem_read and pmem_write both high in IDLE: treated as a write, pmem_err set.
- pmem_err clears only on rst.
- pmem_rdata holds its value until the next completed read. Writes and aborts do not change it.
- cnt width is clog2(LATENCY)+1 bits, with no wrap.

## Timing
- Reset values: pmem_resp=0, pmem_rdata=0, pmem_err=0, state=IDLE, cnt=0.
- The array is not reset; contents persist across rst.
- Request first high in cycle 0 (seen in IDLE) → pmem_resp high in cycle LATENCY+1, i.e. LATENCY+2 cycles from request to response.
- pmem_rdata is valid in the same cycle pmem_resp is high.
- Minimum spacing between responses: LATENCY+3 cycles. A request still high during RECOVER is not accepted; it is accepted in the following IDLE cycle.
- Initiator rule: a request held high after the pmem_resp cycle is treated as a new request once IDLE is reached.
- rst mid-operation (WAIT or RESP): immediate return to IDLE with outputs at reset values.
  - A write in progress is cancelled unless its commit edge has already occurred.
- Read-after-write to the same line returns the new data; the write commits before the next acceptance.

## Test plan
- Reset then idle: rst high 3 cycles then low → resp=0, rdata=0, err=0 for 20 idle cycles.
- Write then read, LATENCY=10:
  - Write addr 0x0000_0040 with wdata = {8{32'hDEADBEEF}} → resp exactly in cycle 11 after request.
  - Read addr 0x0000_005C → resp in cycle 11, rdata = {8{32'hDEADBEEF}}.
- Abort: read addr 0x80 dropped in cycle 4 → no resp. A subsequent read of line 4 completes normally at LATENCY+2 cycles.
- Back-to-back: initiator holds pmem_read through the resp cycle for 2 cycles, then re-requests → exactly two resp pulses, at least LATENCY+3 cycles apart.
- Errors:
  - Read addr 0x0000_0800 with LINES=64 → resp on time, rdata=0, err=1.
  - Simultaneous read+write to 0x20 with data 256'h1 → stored as write, err stays 1 until rst.
- Reset mid-WAIT: rst pulsed at cycle 5 of a write to 0x60 → no resp. A later read of 0x60 returns the prior contents.

Source files
------------

// File: rtl/pmem_line_responder_if.sv
// pmem line bus between a cache (master) and a line-granular memory (slave).
//   pmem_read/pmem_write : request strobes, held by the master until pmem_resp
//   pmem_address         : byte address, line index taken from bits [31:5]
//   pmem_wdata           : 256-bit write line, stable while pmem_write is high
//   pmem_rdata           : 256-bit read line, valid with pmem_resp
//   pmem_resp            : one-cycle completion pulse
//   pmem_err             : sticky protocol/range error flag
interface pmem_if;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;
   logic         pmem_err;

   modport master (
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_rdata, pmem_resp, pmem_err
   );

   modport slave (
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_rdata, pmem_resp, pmem_err
   );
endinterface

// File: rtl/pmem_line_responder.sv
// Line-granular physical-memory responder for the cache pmem handshake.
// Accepts one read or write request at a time and completes it LATENCY+2
// cycles after the request is first seen, with a single registered pmem_resp
// pulse. Out-of-range or read+write-collision requests set a sticky pmem_err.
//   clk  : system clock, all state on rising edge
//   rst  : asynchronous active-high reset (backing store is not reset)
//   pmem : slave side of pmem_if (request in, rdata/resp/err out)
module pmem_line_responder #(
   parameter int unsigned LINES   = 64,
   parameter int unsigned LATENCY = 10
) (
   input  logic  clk,
   input  logic  rst,
   pmem_if.slave pmem
);

   localparam int unsigned IdxW = $clog2(LINES);
   localparam int unsigned CntW = $clog2(LATENCY) + 1;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp,
      StRecover
   } state_e;

   state_e          state_q;
   logic            op_write_q;
   logic [IdxW-1:0] idx_q;
   logic            oor_q;
   logic [CntW-1:0] cnt_q;
   logic            resp_q;
   logic [255:0]    rdata_q;
   logic            err_q;

   logic [255:0]    mem [LINES];

   logic            req_held;
   logic            finish;
   logic            commit_write;
   logic            addr_oor;
   logic            unused_addr;

   // The latched op's own strobe must stay high; dropping it aborts.
   assign req_held     = op_write_q ? pmem.pmem_write : pmem.pmem_read;
   assign finish       = (state_q == StWait) && req_held && (cnt_q == '0);
   assign commit_write = finish && op_write_q && !oor_q;
   assign addr_oor     = pmem.pmem_address[31:5] >= 27'(LINES);
   assign unused_addr  = ^pmem.pmem_address[4:0];

   // Backing store: no reset, contents survive rst. During rst the FSM sits
   // in StIdle, so no write can commit.
   always_ff @(posedge clk) begin
      if (commit_write) begin
         mem[idx_q] <= pmem.pmem_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         op_write_q <= 1'b0;
         idx_q      <= '0;
         oor_q      <= 1'b0;
         cnt_q      <= '0;
         resp_q     <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         resp_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pmem.pmem_read || pmem.pmem_write) begin
                  op_write_q <= pmem.pmem_write;
                  idx_q      <= pmem.pmem_address[5 +: IdxW];
                  oor_q      <= addr_oor;
                  cnt_q      <= CntW'(LATENCY - 1);
                  state_q    <= StWait;
                  if (addr_oor || (pmem.pmem_read && pmem.pmem_write)) begin
                     err_q <= 1'b1;
                  end
               end
            end
            StWait: begin
               if (!req_held) begin
                  state_q <= StIdle;
               end else if (cnt_q == '0) begin
                  state_q <= StResp;
                  resp_q  <= 1'b1;
                  if (!op_write_q) begin
                     rdata_q <= oor_q ? '0 : mem[idx_q];
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StResp: begin
               state_q <= StRecover;
            end
            StRecover: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign pmem.pmem_rdata = rdata_q;
   assign pmem.pmem_resp  = resp_q;
   assign pmem.pmem_err   = err_q;

endmodule
